// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

    // Serializer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Payload bits per frame (8N1).
    localparam int DATA_BITS = 8;

    // Clock cycles per serial bit; integer truncation of the ratio.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_byte_fifo.sv
// Synchronous byte FIFO with registered full/empty flags and a rejected-push pulse.
// Queued data is discarded on reset by clearing the pointers and the count.
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             full_r;
    logic             empty_r;
    logic             overflow_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // A push is taken only when not full; a full FIFO rejects it even if a pop happens too.
    assign push_ok_s = push & ~full_r;
    assign pop_ok_s  = pop & ~empty_r;
    assign pop_data  = mem_r[rd_ptr_r];

    assign full     = full_r;
    assign empty    = empty_r;
    assign overflow = overflow_r;

    // Next occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, count and flags; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r    <= count_next_s;
            full_r     <= (count_next_s == CNT_DEPTH);
            empty_r    <= (count_next_s == CNT_ZERO);
            overflow_r <= push & full_r;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queued in a FIFO are drained by a
// serializer FSM. The line and busy flag are re-registered from the FSM state,
// so the pin lags the state by one cycle while every bit keeps its full length.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       busy,
    output logic       RsTx
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W = ($clog2(CLKS_PER_BIT) < 1) ? 1 : $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

    tx_state_t            state_r;
    logic [CNT_W-1:0]     baud_cnt_r;
    logic [IDX_W-1:0]     bit_idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 tx_r;
    logic                 busy_r;
    logic                 pop_s;
    logic                 bit_end_s;
    logic [7:0]           fifo_data_s;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop_s),
        .pop_data  (fifo_data_s),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    assign bit_end_s = (baud_cnt_r == CNT_LAST);
    assign RsTx      = tx_r;
    assign busy      = busy_r;

    // Pop when idle with data waiting, or at the end of a stop bit to chain frames.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            STOP: begin
                if (bit_end_s && !empty) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            default: pop_s = 1'b0;
        endcase
    end

    // Serializer FSM with baud counter; the counter restarts on every bit or state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            baud_cnt_r <= CNT_ZERO;
            bit_idx_r  <= IDX_ZERO;
            shift_r    <= {DATA_BITS{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    baud_cnt_r <= CNT_ZERO;
                    bit_idx_r  <= IDX_ZERO;
                    if (pop_s) begin
                        shift_r <= fifo_data_s;
                        state_r <= START;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= CNT_ZERO;
                        bit_idx_r  <= IDX_ZERO;
                        state_r    <= DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= CNT_ZERO;
                        shift_r    <= {1'b0, shift_r[DATA_BITS-1:1]};
                        if (bit_idx_r == IDX_LAST) begin
                            bit_idx_r <= IDX_ZERO;
                            state_r   <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + IDX_ONE;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_ONE;
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= CNT_ZERO;
                        if (pop_s) begin
                            shift_r <= fifo_data_s;
                            state_r <= START;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    baud_cnt_r <= CNT_ZERO;
                    bit_idx_r  <= IDX_ZERO;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    // Registered line and busy flag derived from the current FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE:    tx_r <= 1'b1;
                START:   tx_r <= 1'b0;
                DATA:    tx_r <= shift_r[0];
                STOP:    tx_r <= 1'b1;
                default: tx_r <= 1'b1;
            endcase
            busy_r <= (state_r != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a line decoder checks frames against a
// scoreboard of accepted bytes; timing and flag behaviour is checked inline.
module tb_uart_tx_fifo;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       busy;
    logic       RsTx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ovf_count = 0;
    int ovf_base;

    logic [7:0] exp_q[$];
    int         start_q[$];

    logic       rx_active = 1'b0;
    logic       prev_line = 1'b1;
    int         rx_cnt = 0;
    logic [9:0] rx_bits = 10'h000;

    uart_tx_fifo #(
        .CLK_HZ     (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .busy     (busy),
        .RsTx     (RsTx)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic frame_done(input logic [9:0] bits);
        logic       have_exp;
        logic [7:0] exp_byte;
        check("rx_start_bit", {31'd0, bits[0]}, 32'd0);
        check("rx_stop_bit", {31'd0, bits[9]}, 32'd1);
        have_exp = (exp_q.size() != 0);
        check("rx_frame_expected", {31'd0, have_exp}, 32'd1);
        if (have_exp) begin
            exp_byte = exp_q.pop_front();
            check("rx_byte", {24'd0, bits[8:1]}, {24'd0, exp_byte});
        end
    endtask

    // line decoder: detects a falling edge, samples each bit mid-way
    always @(negedge clk) begin
        if (rst) begin
            rx_active = 1'b0;
            rx_cnt    = 0;
            prev_line = 1'b1;
        end else begin
            if (!rx_active) begin
                if (prev_line && (RsTx == 1'b0)) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                rx_cnt++;
            end
            if (rx_active && ((rx_cnt % CPB) == (CPB / 2))) begin
                rx_bits[rx_cnt / CPB] = RsTx;
                if ((rx_cnt / CPB) == 9) begin
                    rx_active = 1'b0;
                    frame_done(rx_bits);
                end
            end
            prev_line = RsTx;
        end
    end

    // overflow pulse counter
    always @(negedge clk) begin
        if (overflow === 1'b1) ovf_count++;
    end

    task automatic wait_drain(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && busy == 1'b0 && !rx_active) done = 1'b1;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset values, no clock edge yet
        #1 rst = 1'b1;
        #1;
        check("rst_RsTx", {31'd0, RsTx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // ---------------- single byte 0xA5, latency
        wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
        @(posedge clk); #1;
        check("t1_empty_after_push", {31'd0, empty}, 32'd0);
        check("t1_line_edge_n", {31'd0, RsTx}, 32'd1);
        @(negedge clk); wr_en = 1'b0;
        @(posedge clk); #1;
        check("t1_line_edge_n1", {31'd0, RsTx}, 32'd1);
        check("t1_empty_after_pop", {31'd0, empty}, 32'd1);
        @(posedge clk); #1;
        check("t1_line_fall_n2", {31'd0, RsTx}, 32'd0);
        check("t1_busy_frame", {31'd0, busy}, 32'd1);
        repeat (100) @(posedge clk); #1;
        check("t1_busy_after", {31'd0, busy}, 32'd0);
        check("t1_empty_after", {31'd0, empty}, 32'd1);
        check("t1_line_after", {31'd0, RsTx}, 32'd1);
        check("t1_decoded", exp_q.size(), 32'd0);

        // ---------------- back-to-back 0x00, 0xFF
        repeat (5) @(negedge clk);
        start_q.delete();
        wr_en = 1'b1; wr_data = 8'h00; exp_q.push_back(8'h00);
        @(negedge clk); wr_data = 8'hFF; exp_q.push_back(8'hFF);
        @(negedge clk); wr_en = 1'b0;
        wait_drain("t2_drain", 400);
        check("t2_frames", start_q.size(), 32'd2);
        if (start_q.size() == 2) check("t2_gap", start_q[1] - start_q[0], 32'd100);

        // ---------------- fill and overflow (depth 4)
        repeat (5) @(negedge clk);
        ovf_base = ovf_count;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_data = 8'(i + 1);
            if (i < 5) exp_q.push_back(8'(i + 1));
            @(posedge clk); #1;
            if (i == 4) check("t3_full_after_5", {31'd0, full}, 32'd1);
            if (i == 5) check("t3_overflow_pulse", {31'd0, overflow}, 32'd1);
        end
        @(negedge clk); wr_en = 1'b0;
        @(posedge clk); #1;
        check("t3_overflow_clear", {31'd0, overflow}, 32'd0);
        wait_drain("t3_drain", 1000);
        check("t3_overflow_count", ovf_count - ovf_base, 32'd1);

        // ---------------- push while full on the STOP->START pop cycle
        repeat (5) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_data = 8'(8'h11 + i); exp_q.push_back(8'(8'h11 + i));
            @(posedge clk); #1;
        end
        check("t4_full_before", {31'd0, full}, 32'd1);
        @(negedge clk); wr_en = 1'b0;
        repeat (96) @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h55;
        @(posedge clk); #1;
        check("t4_overflow_on_pop", {31'd0, overflow}, 32'd1);
        check("t4_full_dropped", {31'd0, full}, 32'd0);
        @(negedge clk); wr_data = 8'h66; exp_q.push_back(8'h66);
        @(posedge clk); #1;
        check("t4_push_accepted_full", {31'd0, full}, 32'd1);
        check("t4_overflow_gone", {31'd0, overflow}, 32'd0);
        @(negedge clk); wr_en = 1'b0;
        wait_drain("t4_drain", 1000);

        // ---------------- reset mid-frame during data bit 3 of 0x3C
        repeat (5) @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h3C;
        @(negedge clk); wr_data = 8'h77;
        @(negedge clk); wr_data = 8'h88;
        @(negedge clk); wr_en = 1'b0;
        repeat (42) @(posedge clk);
        #1;
        check("t5_busy_before", {31'd0, busy}, 32'd1);
        check("t5_empty_before", {31'd0, empty}, 32'd0);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_RsTx", {31'd0, RsTx}, 32'd1);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_empty", {31'd0, empty}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        start_q.delete();
        repeat (300) @(negedge clk);
        check("t5_no_frames", start_q.size(), 32'd0);
        check("t5_line_idle", {31'd0, RsTx}, 32'd1);
        wr_en = 1'b1; wr_data = 8'h5A; exp_q.push_back(8'h5A);
        @(negedge clk); wr_en = 1'b0;
        wait_drain("t5_drain", 400);

        // ---------------- wrap-around: 12 bytes in bursts of 4
        repeat (5) @(negedge clk);
        ovf_base = ovf_count;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 4; i++) begin
                wr_en = 1'b1; wr_data = 8'(8'h80 + b * 4 + i);
                exp_q.push_back(8'(8'h80 + b * 4 + i));
                @(negedge clk);
            end
            wr_en = 1'b0;
            repeat (420) @(negedge clk);
        end
        wait_drain("t6_drain", 600);
        check("t6_no_overflow", ovf_count - ovf_base, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
